// File: rtl/gpio_lite_initiator19_if.sv
// gpio_lite_initiator19_if
// Register port of the 16-bit GPIO lite subunit, as seen by its bus initiator.
//   read      : read strobe, one cycle per access
//   write     : write strobe, one cycle per access (never together with read)
//   addr      : register address, 0 when idle
//   wdata     : write data, 0 when idle
//   rdata     : registered read data, valid the cycle after read=1, else 0
//   interrupt : per-pin interrupt status bits from the subunit
interface gpio_lite_initiator19_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
) ();
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] interrupt;

  modport master (
    output read, write, addr, wdata,
    input  rdata, interrupt
  );

  modport slave (
    input  read, write, addr, wdata,
    output rdata, interrupt
  );
endinterface

// File: rtl/gpio_lite_initiator19.sv
// gpio_lite_initiator19
// Bus initiator for the GPIO lite subunit. Multiplexes host configuration
// accesses and an autonomous interrupt-service engine onto one register port.
// The engine reads INT_STATUS (read-clear) then INPUT_VALUE and delivers both
// as one event on a valid/ready channel.
// Ports:
//   pclk19, reset19          : clock, asynchronous active-high reset
//   cfg_req/we/addr/wdata    : host request, held stable until cfg_ack
//   cfg_ack, cfg_rdata       : one-cycle completion pulse, held read data
//   svc_enable               : gates new interrupt-service grants
//   bus                      : subunit register port (master side)
//   evt_valid/ready          : event handshake
//   evt_status, evt_value    : captured INT_STATUS and INPUT_VALUE
//   svc_count                : events delivered, wraps 255->0
module gpio_lite_initiator19 #(
  parameter int                ADDR_W        = 6,
  parameter int                DATA_W        = 16,
  parameter logic [ADDR_W-1:0] A_INT_STATUS  = 6'h20,
  parameter logic [ADDR_W-1:0] A_INPUT_VALUE = 6'h10
) (
  input  logic                    pclk19,
  input  logic                    reset19,
  input  logic                    cfg_req,
  input  logic                    cfg_we,
  input  logic [ADDR_W-1:0]       cfg_addr,
  input  logic [DATA_W-1:0]       cfg_wdata,
  output logic                    cfg_ack,
  output logic [DATA_W-1:0]       cfg_rdata,
  input  logic                    svc_enable,
  gpio_lite_initiator19_if.master bus,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [DATA_W-1:0]       evt_status,
  output logic [DATA_W-1:0]       evt_value,
  output logic [7:0]              svc_count
);

  typedef enum logic [2:0] {
    IDLE, H_WR, H_RD, H_CAP, S_STAT, S_IN, S_CAP
  } state_t;

  localparam logic GRANT_HOST = 1'b0;
  localparam logic GRANT_SVC  = 1'b1;

  state_t            state, state_next;
  logic              last_grant, last_grant_next;
  logic              read_next, write_next, ack_next;
  logic [ADDR_W-1:0] addr_next;
  logic [DATA_W-1:0] wdata_next;
  logic              host_pend, svc_pend;

  // A request already acknowledged this cycle is not counted again, and no
  // service may start while an undelivered event is still held.
  assign host_pend = cfg_req & ~cfg_ack;
  assign svc_pend  = svc_enable & (|bus.interrupt) & ~evt_valid;

  // Next-state logic. Bus strobes are computed for the state being entered so
  // that the registered outputs line up with that state.
  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    read_next       = 1'b0;
    write_next      = 1'b0;
    ack_next        = 1'b0;
    addr_next       = '0;
    wdata_next      = '0;
    case (state)
      IDLE: begin
        // Round robin only matters when both sources want the bus.
        if (host_pend && (!svc_pend || last_grant == GRANT_SVC)) begin
          last_grant_next = GRANT_HOST;
          addr_next       = cfg_addr;
          if (cfg_we) begin
            state_next = H_WR;
            write_next = 1'b1;
            wdata_next = cfg_wdata;
          end else begin
            state_next = H_RD;
            read_next  = 1'b1;
          end
        end else if (svc_pend) begin
          last_grant_next = GRANT_SVC;
          state_next      = S_STAT;
          read_next       = 1'b1;
          addr_next       = A_INT_STATUS;
        end
      end
      H_WR: begin
        ack_next   = 1'b1;
        state_next = IDLE;
      end
      H_RD:  state_next = H_CAP;
      H_CAP: begin
        ack_next   = 1'b1;
        state_next = IDLE;
      end
      S_STAT: begin
        state_next = S_IN;
        read_next  = 1'b1;
        addr_next  = A_INPUT_VALUE;
      end
      S_IN:    state_next = S_CAP;
      S_CAP:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, arbitration history and registered bus outputs.
  always_ff @(posedge pclk19 or posedge reset19) begin
    if (reset19) begin
      state      <= IDLE;
      last_grant <= GRANT_HOST;
      bus.read   <= 1'b0;
      bus.write  <= 1'b0;
      bus.addr   <= '0;
      bus.wdata  <= '0;
      cfg_ack    <= 1'b0;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
      bus.read   <= read_next;
      bus.write  <= write_next;
      bus.addr   <= addr_next;
      bus.wdata  <= wdata_next;
      cfg_ack    <= ack_next;
    end
  end

  // Read data capture and event delivery. Status arrives while in S_IN and the
  // input value while in S_CAP; a zero status means the interrupt was already
  // cleared (e.g. by a host read), so no event is raised for it.
  always_ff @(posedge pclk19 or posedge reset19) begin
    if (reset19) begin
      cfg_rdata  <= '0;
      evt_valid  <= 1'b0;
      evt_status <= '0;
      evt_value  <= '0;
      svc_count  <= '0;
    end else begin
      if (state == H_CAP) begin
        cfg_rdata <= bus.rdata;
      end
      if (state == S_IN) begin
        evt_status <= bus.rdata;
      end
      if (state == S_CAP) begin
        evt_value <= bus.rdata;
        if (evt_status != '0) begin
          evt_valid <= 1'b1;
          svc_count <= svc_count + 8'd1;
        end
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gpio_lite_initiator19.sv
// tb_gpio_lite_initiator19
// Directed bench for gpio_lite_initiator19 with a small behavioural model of
// the GPIO lite subunit (register file, read-clear INT_STATUS, registered rdata).
module tb_gpio_lite_initiator19;

  logic        pclk19 = 1'b0;
  logic        reset19;
  logic        cfg_req, cfg_we;
  logic [5:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        cfg_ack;
  logic [15:0] cfg_rdata;
  logic        svc_enable;
  logic        evt_valid, evt_ready;
  logic [15:0] evt_status, evt_value;
  logic [7:0]  svc_count;

  int checks   = 0;
  int failures = 0;

  gpio_lite_initiator19_if #(.ADDR_W(6), .DATA_W(16)) bus ();

  gpio_lite_initiator19 dut (
    .pclk19     (pclk19),
    .reset19    (reset19),
    .cfg_req    (cfg_req),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cfg_ack    (cfg_ack),
    .cfg_rdata  (cfg_rdata),
    .svc_enable (svc_enable),
    .bus        (bus),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_status (evt_status),
    .evt_value  (evt_value),
    .svc_count  (svc_count)
  );

  always #5 pclk19 = ~pclk19;

  // Subunit model. irqSet raises status bits; staleIrq holds the interrupt
  // line high independently of the status register.
  logic [15:0] regFile [0:63];
  logic [15:0] intStatus = '0;
  logic [15:0] irqSet = '0;
  logic [15:0] staleIrq = '0;
  logic [15:0] inputValue = '0;

  always @(posedge pclk19) begin
    if (bus.write) regFile[bus.addr] <= bus.wdata;
    if (bus.read) begin
      case (bus.addr)
        6'h20:   bus.rdata <= intStatus;
        6'h10:   bus.rdata <= inputValue;
        default: bus.rdata <= regFile[bus.addr];
      endcase
    end else begin
      bus.rdata <= '0;
    end
    intStatus <= ((bus.read && bus.addr == 6'h20) ? 16'h0 : intStatus) | irqSet;
  end

  assign bus.interrupt = intStatus | staleIrq;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [5:0] a, input logic [15:0] d);
    cfg_req   = 1'b1;
    cfg_we    = we;
    cfg_addr  = a;
    cfg_wdata = d;
  endtask

  task automatic tick();
    @(negedge pclk19);
  endtask

  task automatic waitEvt(input int maxCycles);
    int n = 0;
    while (!evt_valid && n < maxCycles) begin
      tick();
      n++;
    end
    checkOutput("evt_arrived", 32'(evt_valid), 32'd1);
  endtask

  // Read and write strobes must never overlap.
  always @(negedge pclk19) begin
    if (reset19 === 1'b0) checkOutput("rw_exclusive", 32'(bus.read & bus.write), 32'd0);
  end

  int firstRead, firstWrite, busy, sawEvt;
  logic [5:0] addrAtWrite;

  initial begin
    reset19 = 1'b1; cfg_req = 0; cfg_we = 0; cfg_addr = '0; cfg_wdata = '0;
    svc_enable = 0; evt_ready = 1;
    repeat (3) tick();
    checkOutput("rst_read", 32'(bus.read), 0);
    checkOutput("rst_write", 32'(bus.write), 0);
    checkOutput("rst_addr", 32'(bus.addr), 0);
    checkOutput("rst_ack", 32'(cfg_ack), 0);
    checkOutput("rst_evt_valid", 32'(evt_valid), 0);
    checkOutput("rst_count", 32'(svc_count), 0);
    reset19 = 1'b0;
    tick();

    $display("[TB] host write then readback");
    applyStimulus(1'b1, 6'h04, 16'hA5A5);
    tick();
    checkOutput("wr_strobe", 32'(bus.write), 1);
    checkOutput("wr_addr", 32'(bus.addr), 32'h04);
    checkOutput("wr_data", 32'(bus.wdata), 32'hA5A5);
    checkOutput("wr_ack_early", 32'(cfg_ack), 0);
    tick();
    checkOutput("wr_strobe_end", 32'(bus.write), 0);
    checkOutput("wr_addr_idle", 32'(bus.addr), 0);
    checkOutput("wr_data_idle", 32'(bus.wdata), 0);
    checkOutput("wr_ack", 32'(cfg_ack), 1);
    cfg_req = 0;
    tick();
    checkOutput("wr_ack_drop", 32'(cfg_ack), 0);
    applyStimulus(1'b0, 6'h04, 16'h0);
    tick();
    checkOutput("rd_strobe", 32'(bus.read), 1);
    checkOutput("rd_addr", 32'(bus.addr), 32'h04);
    tick();
    checkOutput("rd_ack_early", 32'(cfg_ack), 0);
    tick();
    checkOutput("rd_ack", 32'(cfg_ack), 1);
    checkOutput("rd_data", 32'(cfg_rdata), 32'hA5A5);
    cfg_req = 0;
    tick();
    checkOutput("rd_ack_drop", 32'(cfg_ack), 0);
    checkOutput("rd_data_hold", 32'(cfg_rdata), 32'hA5A5);

    $display("[TB] single interrupt service");
    inputValue = 16'h0008; svc_enable = 1; evt_ready = 1;
    irqSet = 16'h0008;
    tick();
    irqSet = 16'h0;
    checkOutput("svc_not_yet", 32'(bus.read), 0);
    tick();
    checkOutput("svc_rd_stat", 32'(bus.read), 1);
    checkOutput("svc_addr_stat", 32'(bus.addr), 32'h20);
    tick();
    checkOutput("svc_rd_in", 32'(bus.read), 1);
    checkOutput("svc_addr_in", 32'(bus.addr), 32'h10);
    tick();
    checkOutput("svc_rd_done", 32'(bus.read), 0);
    checkOutput("svc_evt_early", 32'(evt_valid), 0);
    tick();
    checkOutput("svc_evt", 32'(evt_valid), 1);
    checkOutput("svc_status", 32'(evt_status), 32'h0008);
    checkOutput("svc_value", 32'(evt_value), 32'h0008);
    checkOutput("svc_count1", 32'(svc_count), 1);
    checkOutput("svc_irq_clear", 32'(bus.interrupt), 0);
    tick();
    checkOutput("svc_evt_accept", 32'(evt_valid), 0);

    $display("[TB] backpressure");
    evt_ready = 0; inputValue = 16'h0001; irqSet = 16'h0001;
    tick();
    irqSet = 16'h0;
    waitEvt(10);
    checkOutput("bp_status1", 32'(evt_status), 32'h0001);
    checkOutput("bp_count2", 32'(svc_count), 2);
    inputValue = 16'h0003; irqSet = 16'h0002;
    tick();
    irqSet = 16'h0;
    busy = 0;
    repeat (6) begin
      tick();
      if (bus.read || bus.write) busy++;
    end
    checkOutput("bp_no_bus", 32'(busy), 0);
    checkOutput("bp_hold_valid", 32'(evt_valid), 1);
    checkOutput("bp_hold_status", 32'(evt_status), 32'h0001);
    evt_ready = 1;
    tick();
    checkOutput("bp_accept", 32'(evt_valid), 0);
    waitEvt(10);
    checkOutput("bp_status2", 32'(evt_status), 32'h0002);
    checkOutput("bp_value2", 32'(evt_value), 32'h0003);
    checkOutput("bp_count3", 32'(svc_count), 3);
    tick();

    $display("[TB] arbitration");
    svc_enable = 0; irqSet = 16'h0010;
    tick();
    irqSet = 16'h0;
    tick();
    svc_enable = 1;
    applyStimulus(1'b1, 6'h08, 16'h1234);
    tick();
    checkOutput("arb1_host_first", 32'(bus.write), 1);
    checkOutput("arb1_no_read", 32'(bus.read), 0);
    tick();
    checkOutput("arb1_ack", 32'(cfg_ack), 1);
    cfg_req = 0;
    tick();
    checkOutput("arb1_svc_next", 32'(bus.read), 1);
    checkOutput("arb1_svc_addr", 32'(bus.addr), 32'h20);
    waitEvt(8);
    checkOutput("arb1_status", 32'(evt_status), 32'h0010);
    checkOutput("arb1_count4", 32'(svc_count), 4);
    tick();
    applyStimulus(1'b1, 6'h09, 16'h5678);
    tick();
    tick();
    cfg_req = 0;
    tick();
    svc_enable = 0; irqSet = 16'h0100;
    tick();
    irqSet = 16'h0;
    tick();
    svc_enable = 1;
    applyStimulus(1'b1, 6'h0A, 16'h9ABC);
    firstRead = 0; firstWrite = 0; addrAtWrite = '0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (bus.read && firstRead == 0) firstRead = k;
      if (bus.write && firstWrite == 0) begin
        firstWrite  = k;
        addrAtWrite = bus.addr;
      end
      if (cfg_ack) cfg_req = 0;
    end
    checkOutput("arb2_svc_first", 32'(firstRead), 1);
    checkOutput("arb2_host_wait", 32'(firstWrite), 5);
    checkOutput("arb2_host_addr", 32'(addrAtWrite), 32'h0A);
    checkOutput("arb2_count5", 32'(svc_count), 5);

    $display("[TB] stale interrupt after host clear");
    svc_enable = 0; irqSet = 16'h0004;
    tick();
    irqSet = 16'h0;
    tick();
    applyStimulus(1'b0, 6'h20, 16'h0);
    tick();
    tick();
    tick();
    checkOutput("stale_host_ack", 32'(cfg_ack), 1);
    checkOutput("stale_host_data", 32'(cfg_rdata), 32'h0004);
    cfg_req = 0;
    staleIrq = 16'h0004; svc_enable = 1;
    tick();
    checkOutput("stale_svc_rd", 32'(bus.read), 1);
    checkOutput("stale_svc_addr", 32'(bus.addr), 32'h20);
    staleIrq = 16'h0;
    sawEvt = 0;
    repeat (5) begin
      tick();
      if (evt_valid) sawEvt = 1;
    end
    checkOutput("stale_no_evt", 32'(sawEvt), 0);
    checkOutput("stale_count", 32'(svc_count), 5);
    checkOutput("stale_status", 32'(evt_status), 0);

    $display("[TB] reset during service");
    irqSet = 16'h0020;
    tick();
    irqSet = 16'h0;
    tick();
    checkOutput("rst_mid_stat", 32'(bus.addr), 32'h20);
    tick();
    checkOutput("rst_mid_in", 32'(bus.addr), 32'h10);
    reset19 = 1'b1;
    irqSet  = 16'h0040;
    #1;
    checkOutput("rst_mid_read", 32'(bus.read), 0);
    checkOutput("rst_mid_addr", 32'(bus.addr), 0);
    checkOutput("rst_mid_ack", 32'(cfg_ack), 0);
    checkOutput("rst_mid_count", 32'(svc_count), 0);
    checkOutput("rst_mid_status", 32'(evt_status), 0);
    tick();
    irqSet = 16'h0;
    tick();
    checkOutput("rst_mid_no_evt", 32'(evt_valid), 0);
    reset19 = 1'b0;
    waitEvt(10);
    checkOutput("rst_post_status", 32'(evt_status), 32'h0040);
    checkOutput("rst_post_value", 32'(evt_value), 32'h0003);
    checkOutput("rst_post_count", 32'(svc_count), 1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpio_lite_initiator19.md
Name: gpio_lite_initiator19

Overview:
Bus initiator that drives the read/write/addr/wdata register port of the 16-bit GPIO lite subunit. It multiplexes two request sources onto that port:
- a host configuration request channel;
- an autonomous interrupt-service engine. On a pending interrupt, the engine reads INT_STATUS (read-clears it) and then INPUT_VALUE, and delivers both as one event on a valid/ready output.

It sits between the local controller and the GPIO subunit, inside the GPIO wrapper.

Parameters:
ADDR_W, 6, register address width
DATA_W, 16, data width and GPIO pin count
A_INT_STATUS, 6'h20, interrupt status register address (read-clear)
A_INPUT_VALUE, 6'h10, synchronised input value register address

Ports:
pclk19  input  1  bus clock
reset19  input  1  asynchronous reset, active high
cfg_req  input  1  host request; held with fields stable until cfg_ack
cfg_we  input  1  1=write, 0=read
cfg_addr  input  ADDR_W  host register address
cfg_wdata  input  DATA_W  host write data
cfg_ack  output  1  one-cycle completion pulse
cfg_rdata  output  DATA_W  host read data; valid with cfg_ack, held until next read ack
svc_enable  input  1  enables autonomous interrupt servicing
interrupt  input  DATA_W  subunit interrupt status bits
rdata  input  DATA_W  subunit read data; registered, valid the cycle after read=1, else 0
read  output  1  subunit read strobe
write  output  1  subunit write strobe
addr  output  ADDR_W  subunit address
wdata  output  DATA_W  subunit write data
evt_valid  output  1  event available
evt_ready  input  1  consumer accepts event
evt_status  output  DATA_W  captured INT_STATUS
evt_value  output  DATA_W  captured INPUT_VALUE
svc_count  output  8  number of events delivered; wraps 255->0

Behaviour:
- Timing: one clock; asynchronous active-high reset; all outputs registered.
- Reset values: read=0, write=0, addr=0, wdata=0, cfg_ack=0, cfg_rdata=0, evt_valid=0, evt_status=0, evt_value=0, svc_count=0; FSM=IDLE; last_grant=HOST.
- Reset asserted mid-transaction aborts it: no cfg_ack is issued and no event is produced.
- Bus rules:
  - read and write are never both high.
  - read/write/addr/wdata are valid for exactly one cycle per access; addr and wdata return to 0 when idle.
- FSM states: IDLE, H_WR, H_RD, H_CAP, S_STAT, S_IN, S_CAP.
- IDLE arbitration:
  - host_pend = cfg_req & ~cfg_ack.
  - svc_pend = svc_enable & (|interrupt) & ~evt_valid.
  - If both are pending, grant the source opposite to last_grant (round robin). Otherwise grant whichever is pending.
  - Update last_grant on each grant.
- Host write, request seen at T:
  - T+1 H_WR: write=1, addr=cfg_addr, wdata=cfg_wdata.
  - T+2: cfg_ack=1; return to IDLE.
- Host read, request seen at T:
  - T+1 H_RD: read=1, addr=cfg_addr.
  - T+2 H_CAP: cfg_rdata<=rdata.
  - T+3: cfg_ack=1; return to IDLE.
- Unmapped host addresses are forwarded unchanged.
- A host read of A_INT_STATUS clears status normally. The engine does not duplicate that data.
- Service, grant at T:
  - T+1 S_STAT: read=1, addr=A_INT_STATUS.
  - T+2 S_IN: read=1, addr=A_INPUT_VALUE; capture status<=rdata.
  - T+3 S_CAP: capture value<=rdata.
  - T+4: if captured status != 0, evt_valid=1 and svc_count++. If status == 0 (stale interrupt), no event and no count.
  - Return to IDLE after T+3.
- Event channel:
  - evt_status/evt_value are stable while evt_valid=1.
  - evt_valid clears on the cycle after evt_valid & evt_ready.
  - No new service starts while evt_valid=1, so events are never dropped. Interrupts stay latched in the subunit.
- svc_enable deasserted mid-service: the current sequence completes. It only gates new grants.
- cfg_ack drops after one cycle. A host holding cfg_req after ack is treated as a new request from the next IDLE cycle.

Test Plan:
1. Host write 0x0004 <- 0xA5A5 -> write=1 with addr=0x04, wdata=0xA5A5 for exactly 1 cycle; cfg_ack 2 cycles after request; readback via host read returns 0xA5A5, ack at T+3.
2. Interrupt bit 3 set with pin high, svc_enable=1, evt_ready=1 -> reads at 0x20 then 0x10 in consecutive cycles; evt_status=0x0008, evt_value has bit3=1; svc_count=1; interrupt clears.
3. evt_ready=0 while a second interrupt arrives -> no bus activity until the first event is accepted; then the second event is delivered; svc_count=2.
4. cfg_req and svc_pend asserted in the same IDLE cycle, repeatedly -> grants alternate host/service; host never waits more than one service sequence (4 cycles).
5. Host read of 0x20 clears status one cycle before the engine's status read -> captured status 0, no evt_valid, svc_count unchanged.
6. Assert reset19 during S_IN -> all outputs 0 immediately; no event, no cfg_ack; after release, a pending interrupt is serviced from IDLE.
